rpsc_interlock_stage: RTL and testbench
=======================================

// Module: rpsc_interlock_stage
// PURPOSE
//  Parametrised power-supply interlock stage for RPSC cards (G1, anode, ...); stages chain via upstream_ok/stage_ok.
//  Combines N fault inputs and an upstream-OK into an ON permission, time-qualifies PS feedback, monitors undervoltage.
//  Latches trips with a cause code until acknowledged. Adds PS-activate timeout, undervoltage trip and fault latching.
// PARAMETERS
//  N_FAULT      7        number of active-high fault inputs (1..32)
//  FAULT_MASK   '0       N_FAULT-bit; 1 = input ignored
//  CNT_W        22       timer counter width
//  QUAL_CYCLES  1562500  cycles ps_act must hold before stage_ok (2 s @ 1.28 us)
//  UV_CYCLES    3125000  cycles u_low must hold in OK to trip (4 s)
//  ACT_TIMEOUT  3125000  max cycles in PERM waiting for ps_act
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous, active-low reset
//  fault        in   N_FAULT  fault inputs (card pos, emergency, door, ...)
//  upstream_ok  in   1        previous stage OK (tie 1 for first stage)
//  ps_act       in   1        PS-active feedback
//  u_low        in   1        undervoltage flag
//  alarm_clr    in   1        trip acknowledge, single-cycle pulse
//  not_alarm    out  1        1 = no unmasked fault present
//  on_perm      out  1        ON permission / PS on request
//  stage_ok     out  1        qualified OK, feeds next stage
//  not_u_low    out  1        0 = undervoltage seen while OK
//  tripped      out  1        latched trip
//  trip_cause   out  3        rpsc_pkg::cause_e
//  state        out  3        rpsc_pkg::state_e, debug
//  first_fault  out  5        index of first fault bit (RPSC_FIRST_FAULT_EN only)
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE, on_perm=0, stage_ok=0, tripped=0, not_alarm=0, not_u_low=1, cause=NONE, cnt=0.
//  flt = |(fault & ~FAULT_MASK); not_alarm <= ~flt every cycle (1-cycle latency).
//  Single counter cnt, cleared on every state change; saturates at all-ones, never wraps.
//  IDLE: !flt & upstream_ok -> PERM. flt -> stays IDLE, no trip.
//  PERM: on_perm=1. ps_act -> QUAL. cnt==ACT_TIMEOUT-1 -> TRIP(ACT_TIMEOUT).
//  QUAL: cnt++ while ps_act; ps_act=0 -> PERM (cnt cleared); cnt==QUAL_CYCLES-1 -> OK.
//        stage_ok rises exactly QUAL_CYCLES cycles after QUAL entry.
//  OK: on_perm=1, stage_ok=1. cnt++ while u_low, cleared when u_low=0; not_u_low=~u_low.
//      cnt==UV_CYCLES-1 -> TRIP(UNDERVOLT). ps_act=0 -> TRIP(PS_LOST).
//  PERM/QUAL/OK: flt -> TRIP(FAULT); !upstream_ok -> IDLE, no trip.
//  TRIP: on_perm=0, stage_ok=0, tripped=1, cause held. alarm_clr & !flt -> IDLE, cause=NONE.
//        alarm_clr while flt ignored (no queuing).
//  Priority per cycle: flt > timeout/UV/PS_LOST > !upstream_ok > advance.
//  on_perm/stage_ok drop in the cycle after the trip condition is sampled.
//  Reset mid-operation: immediate async return to reset values; trip and cause lost.
// CONFIGURATION
//  RPSC_FIRST_FAULT_EN defined: on IDLE/PERM/QUAL/OK->TRIP(FAULT) latch lowest set unmasked bit into first_fault.
//    Held through TRIP, cleared to 0 on exit. Reset 0.
//  Not defined: first_fault tied 0, no capture logic.
// STRUCTURE
//  rpsc_pkg: state_e {IDLE,PERM,QUAL,OK,TRIP}, cause_e {NONE,FAULT,PS_LOST,ACT_TIMEOUT,UNDERVOLT},
//    timing defaults for 1.28 us clk.
//  Sub-module rpsc_hold_timer (clr, en, target, hit), replaces the card-level timer; one instance per stage.
// TESTING (bench params: QUAL_CYCLES=8, UV_CYCLES=15, ACT_TIMEOUT=20, N_FAULT=7)
//  1 release reset, fault=0, upstream_ok=1, ps_act=1 -> on_perm high at cycle 2, stage_ok high 8 cycles after QUAL entry.
//  2 in OK, drive fault[3]=1 -> next cycle tripped=1, cause=FAULT, on_perm=0, first_fault=3 (macro on).
//    alarm_clr while fault=1 -> stays TRIP; clear fault then alarm_clr -> IDLE.
//  3 PERM with ps_act=0 for 20 cycles -> TRIP(ACT_TIMEOUT); ps_act pulse at cycle 19 -> QUAL instead.
//  4 in OK, u_low=1 for 14 cycles then 0 -> no trip, not_u_low toggles; u_low held 15 cycles -> TRIP(UNDERVOLT).
//  5 in QUAL, drop ps_act at cnt=5 -> PERM, stage_ok never rises; restored -> full 8-cycle qualify.
//  6 FAULT_MASK bit 0=1, fault[0]=1 -> not_alarm=1, no trip; upstream_ok drop in OK -> IDLE, tripped stays 0.
//    reset low mid-QUAL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rpsc_pkg.sv
// Shared types, timing defaults (1.28 us clock) and helpers for RPSC interlock stages.
package rpsc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PERM = 3'd1,
        S_QUAL = 3'd2,
        S_OK   = 3'd3,
        S_TRIP = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        C_NONE        = 3'd0,
        C_FAULT       = 3'd1,
        C_PS_LOST     = 3'd2,
        C_ACT_TIMEOUT = 3'd3,
        C_UNDERVOLT   = 3'd4
    } cause_e;

    localparam int unsigned DEF_CNT_W       = 22;
    localparam int unsigned DEF_QUAL_CYCLES = 1562500;  // 2 s
    localparam int unsigned DEF_UV_CYCLES   = 3125000;  // 4 s
    localparam int unsigned DEF_ACT_TIMEOUT = 3125000;  // 4 s

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpsc_hold_timer.sv
// Saturating hold timer: counts enabled cycles, flags when the count equals target.
module rpsc_hold_timer #(
    parameter int unsigned CNT_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == target);

endmodule

// File: rtl/rpsc_interlock_stage.sv
// Chainable PS interlock stage: permission, feedback qualify, UV monitor, latched trips.
// Optional first-fault capture enabled by defining RPSC_FIRST_FAULT_EN.
module rpsc_interlock_stage
    import rpsc_pkg::*;
#(
    parameter int unsigned        N_FAULT     = 7,
    parameter logic [N_FAULT-1:0] FAULT_MASK  = '0,
    parameter int unsigned        CNT_W       = DEF_CNT_W,
    parameter int unsigned        QUAL_CYCLES = DEF_QUAL_CYCLES,
    parameter int unsigned        UV_CYCLES   = DEF_UV_CYCLES,
    parameter int unsigned        ACT_TIMEOUT = DEF_ACT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_FAULT-1:0] fault,
    input  logic               upstream_ok,
    input  logic               ps_act,
    input  logic               u_low,
    input  logic               alarm_clr,
    output logic               not_alarm,
    output logic               on_perm,
    output logic               stage_ok,
    output logic               not_u_low,
    output logic               tripped,
    output logic [2:0]         trip_cause,
    output logic [2:0]         state,
    output logic [4:0]         first_fault
);

    localparam logic [CNT_W-1:0] ACT_T  = CNT_W'(ACT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] QUAL_T = CNT_W'(QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] UV_T   = CNT_W'(UV_CYCLES - 1);

    state_e             cur_st, state_nxt;
    cause_e             cause_q, cause_nxt;
    logic [N_FAULT-1:0] fault_act;
    logic               flt;
    logic               tmr_clr, tmr_en, tmr_hit;
    logic [CNT_W-1:0]   tmr_target;

    assign fault_act = fault & ~FAULT_MASK;
    assign flt       = |fault_act;

    rpsc_hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .target (tmr_target),
        .hit    (tmr_hit)
    );

    // Priority within each state: fault, then timer/feedback trips, then upstream loss, then advance.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = cur_st;
        cause_nxt  = cause_q;
        tmr_en     = 1'b0;
        tmr_target = '0;
        case (cur_st)
            S_IDLE: begin
                if (!flt && upstream_ok) state_nxt = S_PERM;
            end
            S_PERM: begin
                tmr_en     = 1'b1;
                tmr_target = ACT_T;
                if (flt) begin
                    state_nxt = S_TRIP;
                    cause_nxt = C_FAULT;
                end else if (tmr_hit) begin
                    state_nxt = S_TRIP;
                    cause_nxt = C_ACT_TIMEOUT;
                end else if (!upstream_ok) begin
                    state_nxt = S_IDLE;
                end else if (ps_act) begin
                    state_nxt = S_QUAL;
                end
            end
            S_QUAL: begin
                tmr_en     = ps_act;
                tmr_target = QUAL_T;
                if (flt) begin
                    state_nxt = S_TRIP;
                    cause_nxt = C_FAULT;
                end else if (!upstream_ok) begin
                    state_nxt = S_IDLE;
                end else if (!ps_act) begin
                    state_nxt = S_PERM;
                end else if (tmr_hit) begin
                    state_nxt = S_OK;
                end
            end
            S_OK: begin
                tmr_en     = u_low;
                tmr_target = UV_T;
                if (flt) begin
                    state_nxt = S_TRIP;
                    cause_nxt = C_FAULT;
                end else if (u_low && tmr_hit) begin
                    state_nxt = S_TRIP;
                    cause_nxt = C_UNDERVOLT;
                end else if (!ps_act) begin
                    state_nxt = S_TRIP;
                    cause_nxt = C_PS_LOST;
                end else if (!upstream_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            S_TRIP: begin
                // Acknowledge only counts once the fault is gone; it is not remembered.
                if (alarm_clr && !flt) begin
                    state_nxt = S_IDLE;
                    cause_nxt = C_NONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cause_nxt = C_NONE;
            end
        endcase
        tmr_clr = (state_nxt != cur_st) || (cur_st == S_OK && !u_low);
    end

    // Outputs decode the next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_st    <= S_IDLE;
            cause_q   <= C_NONE;
            on_perm   <= 1'b0;
            stage_ok  <= 1'b0;
            tripped   <= 1'b0;
            not_alarm <= 1'b0;
            not_u_low <= 1'b1;
        end else begin
            cur_st    <= state_nxt;
            cause_q   <= cause_nxt;
            on_perm   <= (state_nxt == S_PERM) || (state_nxt == S_QUAL) || (state_nxt == S_OK);
            stage_ok  <= (state_nxt == S_OK);
            tripped   <= (state_nxt == S_TRIP);
            not_alarm <= ~flt;
            not_u_low <= (cur_st == S_OK) ? ~u_low : 1'b1;
        end
    end

    assign state      = cur_st;
    assign trip_cause = cause_q;

`ifdef RPSC_FIRST_FAULT_EN
    logic [4:0] first_fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_fault_q <= '0;
        end else if (cur_st != S_TRIP && state_nxt == S_TRIP && cause_nxt == C_FAULT) begin
            first_fault_q <= lowest_set(32'(fault_act));
        end else if (cur_st == S_TRIP && state_nxt != S_TRIP) begin
            first_fault_q <= '0;
        end
    end

    assign first_fault = first_fault_q;
`else
    assign first_fault = '0;
`endif

endmodule

// File: tb/tb_rpsc_interlock_stage.sv
// Scoreboard bench for rpsc_interlock_stage with short timing parameters and fault[0] masked.
module tb_rpsc_interlock_stage;
    import rpsc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] fault;
    logic       upstream_ok, ps_act, u_low, alarm_clr;
    logic       not_alarm, on_perm, stage_ok, not_u_low, tripped;
    logic [2:0] trip_cause, state;
    logic [4:0] first_fault;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string  tag;
        state_e st;
        cause_e cause;
        logic   na;
        logic   nul;
    } exp_t;

    exp_t sb[$];

    rpsc_interlock_stage #(
        .N_FAULT     (7),
        .FAULT_MASK  (7'b0000001),
        .CNT_W       (22),
        .QUAL_CYCLES (8),
        .UV_CYCLES   (15),
        .ACT_TIMEOUT (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fault       (fault),
        .upstream_ok (upstream_ok),
        .ps_act      (ps_act),
        .u_low       (u_low),
        .alarm_clr   (alarm_clr),
        .not_alarm   (not_alarm),
        .on_perm     (on_perm),
        .stage_ok    (stage_ok),
        .not_u_low   (not_u_low),
        .tripped     (tripped),
        .trip_cause  (trip_cause),
        .state       (state),
        .first_fault (first_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Pops the oldest expectation and compares all state-derived outputs.
    task automatic compare();
        exp_t e;
        logic perm_exp;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        perm_exp = (e.st == S_PERM) || (e.st == S_QUAL) || (e.st == S_OK);
        check({e.tag, "_state"},     32'(state),      32'(e.st));
        check({e.tag, "_cause"},     32'(trip_cause), 32'(e.cause));
        check({e.tag, "_on_perm"},   32'(on_perm),    32'(perm_exp));
        check({e.tag, "_stage_ok"},  32'(stage_ok),   32'(e.st == S_OK));
        check({e.tag, "_tripped"},   32'(tripped),    32'(e.st == S_TRIP));
        check({e.tag, "_not_alarm"}, 32'(not_alarm),  32'(e.na));
        check({e.tag, "_not_u_low"}, 32'(not_u_low),  32'(e.nul));
    endtask

    task automatic expect_now(input string tag, input state_e st, input cause_e c,
                              input logic na, input logic nul);
        sb.push_back('{tag, st, c, na, nul});
        compare();
    endtask

    // One clock: expectation queued with the stimulus, compared 1 ns after the edge.
    task automatic cyc(input string tag, input state_e st, input cause_e c,
                       input logic na, input logic nul);
        sb.push_back('{tag, st, c, na, nul});
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic qualify_to_ok(input string tag);
        cyc({tag, "_perm"}, S_PERM, C_NONE, 1'b1, 1'b1);
        cyc({tag, "_qual"}, S_QUAL, C_NONE, 1'b1, 1'b1);
        repeat (7) cyc({tag, "_qual_hold"}, S_QUAL, C_NONE, 1'b1, 1'b1);
        cyc({tag, "_ok"}, S_OK, C_NONE, 1'b1, 1'b1);
    endtask

    initial begin
        reset       = 1'b0;
        fault       = '0;
        upstream_ok = 1'b1;
        ps_act      = 1'b1;
        u_low       = 1'b0;
        alarm_clr   = 1'b0;
        #12;
        expect_now("reset", S_IDLE, C_NONE, 1'b0, 1'b1);
        check("reset_first_fault", 32'(first_fault), 32'd0);
        reset = 1'b1;

        // Power-up qualify: OK exactly 8 cycles after QUAL entry.
        qualify_to_ok("t1");

        // Unmasked fault in OK, acknowledge while faulted is ignored.
        fault = 7'b0001000;
        cyc("t2_trip", S_TRIP, C_FAULT, 1'b0, 1'b1);
`ifdef RPSC_FIRST_FAULT_EN
        check("t2_first_fault", 32'(first_fault), 32'd3);
`else
        check("t2_first_fault", 32'(first_fault), 32'd0);
`endif
        alarm_clr = 1'b1;
        cyc("t2_clr_ignored", S_TRIP, C_FAULT, 1'b0, 1'b1);
        alarm_clr = 1'b0;
        fault = '0;
        cyc("t2_hold", S_TRIP, C_FAULT, 1'b1, 1'b1);
        alarm_clr = 1'b1;
        cyc("t2_exit", S_IDLE, C_NONE, 1'b1, 1'b1);
        alarm_clr = 1'b0;
        check("t2_first_fault_clr", 32'(first_fault), 32'd0);

        // Unmasked fault while IDLE blocks permission without tripping.
        fault = 7'b0000100;
        cyc("t6_idle_flt", S_IDLE, C_NONE, 1'b0, 1'b1);
        fault = '0;

        // Activation timeout after 20 PERM cycles without feedback.
        ps_act = 1'b0;
        cyc("t3_perm", S_PERM, C_NONE, 1'b1, 1'b1);
        repeat (19) cyc("t3_wait", S_PERM, C_NONE, 1'b1, 1'b1);
        cyc("t3_timeout", S_TRIP, C_ACT_TIMEOUT, 1'b1, 1'b1);
        alarm_clr = 1'b1;
        cyc("t3_ack", S_IDLE, C_NONE, 1'b1, 1'b1);
        alarm_clr = 1'b0;

        // Feedback arriving in the 19th PERM cycle wins.
        cyc("t3b_perm", S_PERM, C_NONE, 1'b1, 1'b1);
        repeat (18) cyc("t3b_wait", S_PERM, C_NONE, 1'b1, 1'b1);
        ps_act = 1'b1;
        cyc("t3b_qual", S_QUAL, C_NONE, 1'b1, 1'b1);

        // Feedback drop mid-qualify restarts the full 8-cycle window.
        repeat (5) cyc("t5_qual", S_QUAL, C_NONE, 1'b1, 1'b1);
        ps_act = 1'b0;
        cyc("t5_drop", S_PERM, C_NONE, 1'b1, 1'b1);
        ps_act = 1'b1;
        cyc("t5_requal", S_QUAL, C_NONE, 1'b1, 1'b1);
        repeat (7) cyc("t5_requal_hold", S_QUAL, C_NONE, 1'b1, 1'b1);
        cyc("t5_ok", S_OK, C_NONE, 1'b1, 1'b1);

        // Undervoltage: 14 cycles is tolerated, 15 trips.
        u_low = 1'b1;
        repeat (14) cyc("t4_uv_short", S_OK, C_NONE, 1'b1, 1'b0);
        u_low = 1'b0;
        cyc("t4_uv_gone", S_OK, C_NONE, 1'b1, 1'b1);
        u_low = 1'b1;
        repeat (14) cyc("t4_uv_long", S_OK, C_NONE, 1'b1, 1'b0);
        cyc("t4_uv_trip", S_TRIP, C_UNDERVOLT, 1'b1, 1'b0);
        u_low = 1'b0;
        cyc("t4_uv_held", S_TRIP, C_UNDERVOLT, 1'b1, 1'b1);
        alarm_clr = 1'b1;
        cyc("t4_ack", S_IDLE, C_NONE, 1'b1, 1'b1);
        alarm_clr = 1'b0;

        // PS feedback lost while OK.
        qualify_to_ok("tps");
        ps_act = 1'b0;
        cyc("tps_lost", S_TRIP, C_PS_LOST, 1'b1, 1'b1);
        ps_act = 1'b1;
        alarm_clr = 1'b1;
        cyc("tps_ack", S_IDLE, C_NONE, 1'b1, 1'b1);
        alarm_clr = 1'b0;

        // Masked fault bit is ignored; upstream loss returns to IDLE untripped.
        fault = 7'b0000001;
        qualify_to_ok("t6");
        upstream_ok = 1'b0;
        cyc("t6_up_drop", S_IDLE, C_NONE, 1'b1, 1'b1);
        upstream_ok = 1'b1;
        fault = '0;

        // Asynchronous reset mid-qualify.
        cyc("t7_perm", S_PERM, C_NONE, 1'b1, 1'b1);
        cyc("t7_qual", S_QUAL, C_NONE, 1'b1, 1'b1);
        repeat (3) cyc("t7_qual_hold", S_QUAL, C_NONE, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        expect_now("t7_async_rst", S_IDLE, C_NONE, 1'b0, 1'b1);
        check("t7_first_fault", 32'(first_fault), 32'd0);
        #3;
        reset = 1'b1;
        cyc("t7_recover", S_PERM, C_NONE, 1'b1, 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
